// File: rtl/riscv_register_file.sv
// rtl/riscv_register_file.sv - RV32I integer register file, 2 async read ports, 1 sync write port (optional REGFILE_BYPASS_EN forwarding)
module riscv_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data1,
  output logic [DATA_WIDTH-1:0] data2
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  wr_en;

  // x0 is never a write target, so a write to it is simply dropped
  assign wr_en = we && (rd != '0);

  // next-state: copy current contents and overlay the single writeback update
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[rd] = data_in;
    end
    regs_d[0] = '0;
  end

  // state register: reset clears everything and overrides a same-edge write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // combinational read with write-through forwarding of the in-flight rd value
  always_comb begin
    data1 = (rs1 == '0) ? '0 : regs_q[rs1];
    data2 = (rs2 == '0) ? '0 : regs_q[rs2];
    if (wr_en && !reset && (rd == rs1)) begin
      data1 = data_in;
    end
    if (wr_en && !reset && (rd == rs2)) begin
      data2 = data_in;
    end
  end
`else
  // combinational read of stored contents; x0 always reads zero
  always_comb begin
    data1 = (rs1 == '0) ? '0 : regs_q[rs1];
    data2 = (rs2 == '0) ? '0 : regs_q[rs2];
  end
`endif

endmodule

// File: tb/tb_riscv_register_file.sv
// tb/tb_riscv_register_file.sv - self-checking bench for riscv_register_file
module tb_riscv_register_file;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] data_in;
  logic [31:0] data1;
  logic [31:0] data2;

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          total;
  int          bad;

  riscv_register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .NUM_REGS(32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .data_in (data_in),
    .data1   (data1),
    .data2   (data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    logic [31:0] v;
    v = (idx == 5'd0) ? 32'd0 : model[idx];
`ifdef REGFILE_BYPASS_EN
    if (we && !reset && rd != 5'd0 && rd == idx) v = data_in;
`endif
    return v;
  endfunction

  // one rising edge; the model takes the same update the DUT should
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (we && rd != 5'd0) begin
      model[rd] = data_in;
    end
    #1;
  endtask

  // push expectation for the current inputs, let reads settle, pop and compare
  task automatic check(input string tag);
    exp_t e;
    e.tag = tag;
    e.e1  = model_read(rs1);
    e.e2  = model_read(rs2);
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    total++;
    assert (data1 === e.e1) else begin
      bad++;
      $error("FAIL %s data1 observed=%h expected=%h", e.tag, data1, e.e1);
    end
    total++;
    assert (data2 === e.e2) else begin
      bad++;
      $error("FAIL %s data2 observed=%h expected=%h", e.tag, data2, e.e2);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    reset = 1'b1; we = 1'b0; rs1 = '0; rs2 = '0; rd = '0; data_in = '0;

    // T1: reset
    tick();
    reset = 1'b0; rs1 = 5'd3; rs2 = 5'd2;
    check("t1_reset");
    if (data1 !== 32'd0 || data2 !== 32'd0) begin
      bad++;
      $error("FAIL t1_const observed=%h/%h expected=0/0", data1, data2);
    end
    total++;

    // T2: write x3
    we = 1'b1; rd = 5'd3; data_in = 32'd16;
    tick();
    we = 1'b0;
    check("t2_write");
    total++;
    assert (data1 === 32'd16) else begin
      bad++;
      $error("FAIL t2_const observed=%h expected=%h", data1, 32'd16);
    end

    // T3: we=0 blocks write, then enable it
    we = 1'b0; rd = 5'd2; data_in = 32'd8;
    tick();
    check("t3_no_write");
    we = 1'b1;
    tick();
    we = 1'b0;
    check("t3_write");
    total++;
    assert (data2 === 32'd8 && data1 === 32'd16) else begin
      bad++;
      $error("FAIL t3_const observed=%h/%h expected=%h/%h", data1, data2, 32'd16, 32'd8);
    end

    // T4: write to x0 ignored
    we = 1'b1; rd = 5'd0; data_in = 32'hDEADBEEF; rs1 = 5'd0;
    check("t4_x0_pre");
    tick();
    we = 1'b0;
    check("t4_x0_post");

    // T5: reset beats a same-edge write
    we = 1'b1; rd = 5'd5; data_in = 32'd7; reset = 1'b1; rs1 = 5'd5; rs2 = 5'd3;
    check("t5_reset_pre");
    tick();
    reset = 1'b0; we = 1'b0;
    check("t5_reset_post");

    // T6: read during write of same register
    we = 1'b1; rd = 5'd4; data_in = 32'd9; rs1 = 5'd4; rs2 = 5'd4;
    check("t6_pre");
    total++;
`ifdef REGFILE_BYPASS_EN
    assert (data1 === 32'd9) else begin
      bad++;
      $error("FAIL t6_bypass observed=%h expected=%h", data1, 32'd9);
    end
`else
    assert (data1 === 32'd0) else begin
      bad++;
      $error("FAIL t6_old observed=%h expected=%h", data1, 32'd0);
    end
`endif
    tick();
    we = 1'b0;
    check("t6_post");

    // fill every register with a distinct pattern, then read all back
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; rd = 5'(i); data_in = 32'hA5000000 ^ (32'(i) * 32'h01010101);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      check("readback");
    end

    // randomized mix of writes and reads
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 31));
      data_in = $urandom;
      rs1 = 5'($urandom_range(0, 31));
      rs2 = (n % 4 == 0) ? rd : 5'($urandom_range(0, 31));
      reset = (n % 67 == 66);
      check("rand_pre");
      tick();
      reset = 1'b0; we = 1'b0;
      check("rand_post");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
